// File: rtl/muldiv_sched_if.sv
// Request bus between EX decode and the HI/LO multiply/divide scheduler.
// The master (EX) issues operations; the slave (scheduler) accepts them and returns MF* data.
interface muldiv_sched_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic [31:0] rd_data;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rd_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rd_data
    );
endinterface

// File: rtl/muldiv_sched.sv
// Owns architectural HI/LO and sequences the iterative multiply/divide unit:
// launch, wait for done, local divide-by-zero, flush and hung-unit watchdog.
module muldiv_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    muldiv_sched_if.slave req,
    output logic        unit_start,
    output logic        unit_sgn,
    output logic        unit_div,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_abort,
    input  logic        unit_done,
    input  logic [31:0] unit_hi,
    input  logic [31:0] unit_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [2:0] OP_MFHI = 3'd6;
    localparam logic [2:0] OP_MFLO = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DZERO} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;

    logic accept;
    logic is_arith;
    logic div_zero;
    logic commit_unit;
    logic commit_dz;
    logic wd_fire;

    // Opcodes 0..3 go to the unit; op[1] selects divide.
    assign accept   = req.req_valid & req.req_ready;
    assign is_arith = ~req.req_op[2];
    assign div_zero = is_arith & req.req_op[1] & (req.req_b == 32'd0);
    assign busy     = (state_reg != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req.req_ready = 1'b0;
        req.rd_data   = 32'd0;
        unit_start    = 1'b0;
        unit_abort    = 1'b0;
        commit_unit   = 1'b0;
        commit_dz     = 1'b0;
        wd_fire       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req.req_ready = ~flush & ~rst;
                if (req.req_valid & ~flush & ~rst) begin
                    if (req.req_op == OP_MFHI) req.rd_data = hi;
                    if (req.req_op == OP_MFLO) req.rd_data = lo;
                    if (is_arith) state_next = div_zero ? S_DZERO : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (flush) begin
                    unit_abort = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    unit_start = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Flush beats a coincident done: the result is dropped.
                if (flush) begin
                    unit_abort = 1'b1;
                    state_next = S_IDLE;
                end else if (unit_done) begin
                    commit_unit = 1'b1;
                    state_next  = S_IDLE;
                end else if (cnt_reg == CNT_MAX) begin
                    unit_abort = 1'b1;
                    wd_fire    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DZERO: begin
                if (flush) begin
                    unit_abort = 1'b1;
                end else begin
                    commit_dz = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            unit_a      <= 32'd0;
            unit_b      <= 32'd0;
            unit_sgn    <= 1'b0;
            unit_div    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt_reg <= (state_reg == S_WAIT) ? cnt_reg + 1'b1 : '0;
            // Divide-by-zero also latches operand a; DZERO commits it as HI.
            if (accept && is_arith) begin
                unit_a   <= req.req_a;
                unit_b   <= req.req_b;
                unit_sgn <= ~req.req_op[0];
                unit_div <= req.req_op[1];
            end
            if (accept && req.req_op == OP_MTHI) hi <= req.req_a;
            if (accept && req.req_op == OP_MTLO) lo <= req.req_a;
            if (commit_unit) begin
                hi <= unit_hi;
                lo <= unit_lo;
            end
            if (commit_dz) begin
                hi <= unit_a;
                lo <= 32'hFFFF_FFFF;
            end
            if (wd_fire) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: a stand-in unit is driven by hand and HI/LO/MF* results
// are checked against a queue of expected values filled when each operation is issued.
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        unit_start, unit_sgn, unit_div, unit_abort, unit_done;
    logic [31:0] unit_a, unit_b, unit_hi, unit_lo, hi, lo;
    logic        busy, timeout_err;

    muldiv_sched_if bus ();

    muldiv_sched #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req         (bus),
        .unit_start  (unit_start),
        .unit_sgn    (unit_sgn),
        .unit_div    (unit_div),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_abort  (unit_abort),
        .unit_done   (unit_done),
        .unit_hi     (unit_hi),
        .unit_lo     (unit_lo),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    bit          start_seen = 1'b0;

    always @(negedge clk) if (unit_start === 1'b1) start_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
    endtask

    task automatic drop();
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; unit_done = 1'b0; unit_hi = 32'd0; unit_lo = 32'd0;
        drop();
        #3;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_rd", bus.rd_data, 32'd0);

        // MULT -3 * 7, unit done in the fifth WAIT cycle
        drive(3'd0, 32'hFFFF_FFFD, 32'd7);
        sb_push(32'hFFFF_FFFF);
        sb_push(32'hFFFF_FFEB);
        chk("mult_ready", {31'd0, bus.req_ready}, 32'd1);
        tick(); drop();
        chk("mult_start", {31'd0, unit_start}, 32'd1);
        chk("mult_busy", {31'd0, busy}, 32'd1);
        chk("mult_a", unit_a, 32'hFFFF_FFFD);
        chk("mult_sgn", {30'd0, unit_sgn, unit_div}, 32'd2);
        tick();
        chk("mult_start_off", {31'd0, unit_start}, 32'd0);
        for (int i = 2; i <= 5; i++) tick();
        unit_done = 1'b1; unit_hi = 32'hFFFF_FFFF; unit_lo = 32'hFFFF_FFEB;
        tick();
        unit_done = 1'b0;
        sb_check("mult_hi", hi);
        sb_check("mult_lo", lo);
        chk("mult_idle", {31'd0, busy}, 32'd0);

        // DIVU 100 / 0 handled locally
        start_seen = 1'b0;
        drive(3'd3, 32'd100, 32'd0);
        sb_push(32'd100);
        sb_push(32'hFFFF_FFFF);
        tick(); drop();
        chk("dz_busy", {31'd0, busy}, 32'd1);
        tick();
        sb_check("dz_hi", hi);
        sb_check("dz_lo", lo);
        chk("dz_idle", {31'd0, busy}, 32'd0);
        chk("dz_no_start", {31'd0, start_seen}, 32'd0);

        // DIV 50 / 7 with MFLO stalled during WAIT
        drive(3'd2, 32'd50, 32'd7);
        tick(); drop();
        chk("div_sgn", {30'd0, unit_sgn, unit_div}, 32'd3);
        tick();
        drive(3'd7, 32'd0, 32'd0);
        sb_push(32'd7);
        chk("mflo_stall1", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("mflo_stall2", {31'd0, bus.req_ready}, 32'd0);
        unit_done = 1'b1; unit_hi = 32'd1; unit_lo = 32'd7;
        #1;
        chk("mflo_done_stall", {31'd0, bus.req_ready}, 32'd0);
        tick();
        unit_done = 1'b0;
        #1;
        chk("mflo_ready", {31'd0, bus.req_ready}, 32'd1);
        sb_check("mflo_rd", bus.rd_data);
        tick(); drop();

        // MTHI then MFHI back to back
        drive(3'd4, 32'h0000_1234, 32'd0);
        chk("mthi_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        drive(3'd6, 32'd0, 32'd0);
        sb_push(32'h0000_1234);
        chk("mfhi_ready", {31'd0, bus.req_ready}, 32'd1);
        sb_check("mfhi_rd", bus.rd_data);
        tick(); drop();

        // flush 3 cycles into WAIT, coincident with done
        drive(3'd1, 32'd5, 32'd6);
        tick(); drop();
        tick(); tick(); tick();
        flush = 1'b1; unit_done = 1'b1; unit_hi = 32'hDEAD_BEEF; unit_lo = 32'hDEAD_BEEF;
        #1;
        chk("fl_abort", {31'd0, unit_abort}, 32'd1);
        tick();
        flush = 1'b0; unit_done = 1'b0;
        #1;
        chk("fl_idle", {31'd0, busy}, 32'd0);
        chk("fl_abort_off", {31'd0, unit_abort}, 32'd0);
        chk("fl_hi", hi, 32'h0000_1234);
        chk("fl_lo", lo, 32'd7);

        // flush in LAUNCH suppresses start
        drive(3'd0, 32'd2, 32'd3);
        tick(); drop();
        flush = 1'b1;
        #1;
        chk("flL_start", {31'd0, unit_start}, 32'd0);
        chk("flL_abort", {31'd0, unit_abort}, 32'd1);
        tick();
        chk("flL_idle", {31'd0, busy}, 32'd0);

        // flush in IDLE squashes MTLO (flush still high)
        drive(3'd5, 32'd999, 32'd0);
        chk("flI_ready", {31'd0, bus.req_ready}, 32'd0);
        tick(); drop();
        flush = 1'b0;
        chk("flI_lo", lo, 32'd7);

        // done outside WAIT is ignored
        unit_done = 1'b1; unit_hi = 32'hAAAA_AAAA; unit_lo = 32'h5555_5555;
        tick();
        unit_done = 1'b0;
        chk("stray_done_hi", hi, 32'h0000_1234);

        // watchdog: done never comes
        drive(3'd0, 32'd1, 32'd2);
        tick(); drop();
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 64) chk("wd_abort", {31'd0, unit_abort}, 32'd1);
            else if (i == 1 || i == 63) chk("wd_no_abort", {31'd0, unit_abort}, 32'd0);
        end
        tick();
        chk("wd_tmo", {31'd0, timeout_err}, 32'd1);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        drive(3'd6, 32'd0, 32'd0);
        sb_push(32'h0000_1234);
        sb_check("wd_mfhi", bus.rd_data);
        tick(); drop();

        // reset mid-operation
        drive(3'd0, 32'd4, 32'd4);
        tick(); drop();
        rst = 1'b1;
        #1;
        chk("mid_rst_abort", {31'd0, unit_abort}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_tmo", {31'd0, timeout_err}, 32'd0);
        tick();
        rst = 1'b0;

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
